// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types and constants for the dcache write-back buffer: entry layout,
// read-path FSM encoding and the line geometry of the dcache memory port.
package dcache_wb_buffer_pkg;

  localparam int LINE_LEN    = 128;
  localparam int TAG_MSB     = 31;
  localparam int TAG_LSB     = 4;
  localparam int LINE_ADDR_W = TAG_MSB - TAG_LSB + 1;
  localparam int WB_DEPTH    = 4;

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [LINE_LEN-1:0]    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_FWD      = 2'd1,
    R_MEM_REQ  = 2'd2,
    R_MEM_WAIT = 2'd3
  } wb_rd_state_e;

endpackage

// File: rtl/dcache_wb_buffer_match.sv
// Combinational search of the buffered lines for a fill address; when the same
// line is buffered more than once, the youngest copy (nearest below wr_ptr) wins.
module dcache_wb_buffer_match
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t              i_entries [DEPTH],
  input  logic [PTR_W-1:0]       i_wr_ptr,
  input  logic [LINE_ADDR_W-1:0] i_line_addr,
  output logic                   o_hit,
  output logic [LINE_LEN-1:0]    o_data
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    o_hit  = 1'b0;
    o_data = '0;
    idx    = '0;
    // Walk from oldest to youngest so the last hit written is the youngest one.
    for (int k = DEPTH; k >= 1; k--) begin
      idx = i_wr_ptr - PTR_W'(k);
      if (i_entries[idx].valid && (i_entries[idx].line_addr == i_line_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache memory master port and main memory:
// absorbs evicted lines, drains them in FIFO order and forwards fills on a hit.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int LINE_W = LINE_LEN,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] s_write_addr,
  input  logic              s_write_addr_valid,
  output logic              s_write_addr_ready,
  input  logic [LINE_W-1:0] s_write_data,
  input  logic [ADDR_W-1:0] s_read_addr,
  input  logic              s_read_addr_valid,
  output logic              s_read_addr_ready,
  output logic [LINE_W-1:0] s_read_data,
  output logic              s_read_data_valid,
  output logic [ADDR_W-1:0] m_write_addr,
  output logic              m_write_addr_valid,
  input  logic              m_write_addr_ready,
  output logic [LINE_W-1:0] m_write_data,
  output logic [ADDR_W-1:0] m_read_addr,
  output logic              m_read_addr_valid,
  input  logic [LINE_W-1:0] m_read_data,
  input  logic              m_read_data_valid,
  output logic [1:0]        o_dbg_rd_state
);

  // Every channel transfers on a cycle where its valid and ready are both high;
  // a valid, once raised, holds its payload stable until that cycle.

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  wb_rd_state_e           r_state;
  wb_rd_state_e           w_state_next;
  logic [LINE_ADDR_W-1:0] r_rd_line;
  logic [LINE_W-1:0]      r_fwd_data;
  logic [LINE_W-1:0]      r_rd_data;
  logic                   r_rd_valid;

  logic              w_enq;
  logic              w_pop;
  logic              w_rd_ready;
  logic              w_rd_acc;
  logic              w_mrd_valid;
  logic              w_hit;
  logic [LINE_W-1:0] w_hit_data;
  logic              w_unused;

  assign w_unused = ^{s_write_addr[TAG_LSB-1:0], s_read_addr[TAG_LSB-1:0]};

  // Ready is forced low while reset is held so nothing looks acceptable.
  assign s_write_addr_ready = rst_ni && (r_count != (PTR_W+1)'(DEPTH));
  assign w_enq              = s_write_addr_valid && s_write_addr_ready;
  assign m_write_addr_valid = (r_count != '0);
  assign w_pop              = m_write_addr_valid && m_write_addr_ready;
  assign m_write_addr       = {r_entries[r_rd_ptr].line_addr, 4'b0000};
  assign m_write_data       = r_entries[r_rd_ptr].data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_wr_ptr] <= '{valid: 1'b1,
                                 line_addr: s_write_addr[TAG_MSB:TAG_LSB],
                                 data: s_write_data};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  dcache_wb_buffer_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .i_entries   (r_entries),
    .i_wr_ptr    (r_wr_ptr),
    .i_line_addr (s_read_addr[TAG_MSB:TAG_LSB]),
    .o_hit       (w_hit),
    .o_data      (w_hit_data)
  );

  assign w_rd_acc = s_read_addr_valid && w_rd_ready;

  always_comb begin
    w_state_next = r_state;
    w_rd_ready   = 1'b0;
    w_mrd_valid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        // A same-cycle eviction goes first so a fill always sees that line.
        w_rd_ready = rst_ni && !s_write_addr_valid;
        if (s_read_addr_valid && w_rd_ready) w_state_next = w_hit ? R_FWD : R_MEM_REQ;
      end
      R_FWD:      w_state_next = R_IDLE;
      R_MEM_REQ: begin
        w_mrd_valid  = 1'b1;
        w_state_next = R_MEM_WAIT;
      end
      R_MEM_WAIT: if (m_read_data_valid) w_state_next = R_IDLE;
      default:    w_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      r_rd_line  <= '0;
      r_fwd_data <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= 1'b0;
      if (w_rd_acc) begin
        r_rd_line  <= s_read_addr[TAG_MSB:TAG_LSB];
        r_fwd_data <= w_hit_data;
      end
      if (r_state == R_FWD) begin
        r_rd_data  <= r_fwd_data;
        r_rd_valid <= 1'b1;
      end
      if ((r_state == R_MEM_WAIT) && m_read_data_valid) begin
        r_rd_data  <= m_read_data;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign s_read_addr_ready = w_rd_ready;
  assign s_read_data       = r_rd_data;
  assign s_read_data_valid = r_rd_valid;
  assign m_read_addr       = {r_rd_line, 4'b0000};
  assign m_read_addr_valid = w_mrd_valid;
  assign o_dbg_rd_state    = r_state;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: drain, full handling, forwarding,
// miss path, write/read collision and asynchronous reset mid-fill.
module tb_dcache_wb_buffer;

  logic         clk;
  logic         rst_ni;
  logic [31:0]  s_write_addr;
  logic         s_write_addr_valid;
  logic         s_write_addr_ready;
  logic [127:0] s_write_data;
  logic [31:0]  s_read_addr;
  logic         s_read_addr_valid;
  logic         s_read_addr_ready;
  logic [127:0] s_read_data;
  logic         s_read_data_valid;
  logic [31:0]  m_write_addr;
  logic         m_write_addr_valid;
  logic         m_write_addr_ready;
  logic [127:0] m_write_data;
  logic [31:0]  m_read_addr;
  logic         m_read_addr_valid;
  logic [127:0] m_read_data;
  logic         m_read_data_valid;
  logic [1:0]   o_dbg_rd_state;

  dcache_wb_buffer dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .s_write_addr       (s_write_addr),
    .s_write_addr_valid (s_write_addr_valid),
    .s_write_addr_ready (s_write_addr_ready),
    .s_write_data       (s_write_data),
    .s_read_addr        (s_read_addr),
    .s_read_addr_valid  (s_read_addr_valid),
    .s_read_addr_ready  (s_read_addr_ready),
    .s_read_data        (s_read_data),
    .s_read_data_valid  (s_read_data_valid),
    .m_write_addr       (m_write_addr),
    .m_write_addr_valid (m_write_addr_valid),
    .m_write_addr_ready (m_write_addr_ready),
    .m_write_data       (m_write_data),
    .m_read_addr        (m_read_addr),
    .m_read_addr_valid  (m_read_addr_valid),
    .m_read_data        (m_read_data),
    .m_read_data_valid  (m_read_data_valid),
    .o_dbg_rd_state     (o_dbg_rd_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Scoreboard
  int          n_vec;
  int          n_miss;
  int          mrd_cnt;
  int          mrd_snap;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  always @(posedge clk) if (m_read_addr_valid) mrd_cnt++;

  task automatic check_vec(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic v, input logic [31:0] a, input logic [127:0] d);
    s_write_addr_valid = v;
    s_write_addr       = a;
    s_write_data       = d;
  endtask

  task automatic set_read(input logic v, input logic [31:0] a);
    s_read_addr_valid = v;
    s_read_addr       = a;
  endtask

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D1   = {4{32'hD1D1_0001}};
  localparam logic [127:0] D2   = {4{32'hD2D2_0002}};
  localparam logic [127:0] D_C  = {4{32'hC011_1DE0}};
  localparam logic [127:0] D_M  = 128'h11223344_55667788_99AABBCC_DDEEFFEE;

  initial begin
    n_vec = 0; n_miss = 0; mrd_cnt = 0;
    rst_ni = 1'b0;
    set_write(1'b0, 32'h0, 128'h0);
    set_read(1'b0, 32'h0);
    m_write_addr_ready = 1'b0;
    m_read_data        = '0;
    m_read_data_valid  = 1'b0;

    // Reset state
    repeat (2) tick();
    check_vec("rst_wr_ready", s_write_addr_ready, 1'b0);
    check_vec("rst_rd_ready", s_read_addr_ready, 1'b0);
    check_vec("rst_mw_valid", m_write_addr_valid, 1'b0);
    check_vec("rst_mw_addr", m_write_addr, 32'h0);
    check_vec("rst_rd_valid", s_read_data_valid, 1'b0);
    rst_ni = 1'b1;
    #1;
    check_vec("rel_wr_ready", s_write_addr_ready, 1'b1);
    check_vec("rel_rd_ready", s_read_addr_ready, 1'b1);

    // Drain with a stalled memory
    tick();
    set_write(1'b1, 32'h0000_1230, D_A5);
    tick();
    set_write(1'b0, 32'h0, 128'h0);
    for (int i = 0; i < 3; i++) begin
      check_vec("drain_valid", m_write_addr_valid, 1'b1);
      check_vec("drain_addr", m_write_addr, 32'h0000_1230);
      check_vec("drain_data", m_write_data, D_A5);
      tick();
    end
    m_write_addr_ready = 1'b1;
    tick();
    m_write_addr_ready = 1'b0;
    #1;
    check_vec("drain_popped", m_write_addr_valid, 1'b0);

    // Fill to DEPTH, hold a fifth write, pop and refill
    for (int i = 0; i < 4; i++) begin
      set_write(1'b1, 32'h0000_2000 + 32'(i * 16), 128'(i));
      exp_q.push_back(32'h0000_2000 + 32'(i * 16));
      tick();
    end
    set_write(1'b1, 32'h0000_2040, 128'd4);
    #1;
    check_vec("full_ready", s_write_addr_ready, 1'b0);
    tick();
    check_vec("fifth_held", s_write_addr_ready, 1'b0);
    m_write_addr_ready = 1'b1;
    #1;
    exp_addr = exp_q.pop_front();
    check_vec("full_pop_addr", m_write_addr, exp_addr);
    check_vec("full_pop_data", m_write_data, 128'd0);
    tick();
    check_vec("ready_after_pop", s_write_addr_ready, 1'b1);
    exp_q.push_back(32'h0000_2040);
    exp_addr = exp_q.pop_front();
    check_vec("enq_pop_addr", m_write_addr, exp_addr);
    tick();
    m_write_addr_ready = 1'b0;
    set_write(1'b1, 32'h0000_2050, 128'd5);
    exp_q.push_back(32'h0000_2050);
    #1;
    check_vec("enq_pop_count", s_write_addr_ready, 1'b1);
    tick();
    set_write(1'b0, 32'h0, 128'h0);
    #1;
    check_vec("refull_ready", s_write_addr_ready, 1'b0);
    m_write_addr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = exp_q.pop_front();
      check_vec("drain_order", m_write_addr, exp_addr);
      tick();
    end
    m_write_addr_ready = 1'b0;
    #1;
    check_vec("fill_empty", m_write_addr_valid, 1'b0);

    // Forward youngest duplicate with memory stalled
    mrd_snap = mrd_cnt;
    set_write(1'b1, 32'h0000_4560, D1);
    tick();
    set_write(1'b1, 32'h0000_4560, D2);
    tick();
    set_write(1'b0, 32'h0, 128'h0);
    set_read(1'b1, 32'h0000_4564);
    #1;
    check_vec("fwd_rd_ready", s_read_addr_ready, 1'b1);
    tick();
    set_read(1'b0, 32'h0);
    check_vec("fwd_state", o_dbg_rd_state, 2'd1);
    check_vec("fwd_early", s_read_data_valid, 1'b0);
    tick();
    check_vec("fwd_valid", s_read_data_valid, 1'b1);
    check_vec("fwd_data", s_read_data, D2);
    tick();
    check_vec("fwd_pulse", s_read_data_valid, 1'b0);
    check_vec("fwd_hold", s_read_data, D2);
    check_vec("fwd_no_mem", 32'(mrd_cnt - mrd_snap), 32'd0);
    check_vec("fwd_head_old", m_write_data, D1);
    m_write_addr_ready = 1'b1;
    repeat (2) tick();
    m_write_addr_ready = 1'b0;

    // Miss goes to memory
    set_read(1'b1, 32'h0000_8000);
    tick();
    set_read(1'b0, 32'h0);
    check_vec("miss_req_valid", m_read_addr_valid, 1'b1);
    check_vec("miss_req_addr", m_read_addr, 32'h0000_8000);
    check_vec("miss_rd_ready", s_read_addr_ready, 1'b0);
    tick();
    check_vec("miss_req_pulse", m_read_addr_valid, 1'b0);
    check_vec("miss_wait_state", o_dbg_rd_state, 2'd3);
    tick();
    m_read_data       = D_M;
    m_read_data_valid = 1'b1;
    tick();
    m_read_data_valid = 1'b0;
    check_vec("miss_valid", s_read_data_valid, 1'b1);
    check_vec("miss_data", s_read_data, D_M);
    tick();
    check_vec("miss_pulse", s_read_data_valid, 1'b0);

    // Write/read collision on the same line
    set_write(1'b1, 32'h0000_9990, D_C);
    set_read(1'b1, 32'h0000_9990);
    #1;
    check_vec("coll_rd_block", s_read_addr_ready, 1'b0);
    check_vec("coll_wr_ready", s_write_addr_ready, 1'b1);
    tick();
    set_write(1'b0, 32'h0, 128'h0);
    #1;
    check_vec("coll_rd_ready", s_read_addr_ready, 1'b1);
    tick();
    set_read(1'b0, 32'h0);
    tick();
    check_vec("coll_valid", s_read_data_valid, 1'b1);
    check_vec("coll_data", s_read_data, D_C);
    m_write_addr_ready = 1'b1;
    tick();
    m_write_addr_ready = 1'b0;

    // Asynchronous reset in R_MEM_WAIT with three lines buffered
    for (int i = 0; i < 3; i++) begin
      set_write(1'b1, 32'h0000_A000 + 32'(i * 16), 128'(i + 16));
      tick();
    end
    set_write(1'b0, 32'h0, 128'h0);
    set_read(1'b1, 32'h0000_B000);
    tick();
    set_read(1'b0, 32'h0);
    tick();
    check_vec("ar_wait_state", o_dbg_rd_state, 2'd3);
    check_vec("ar_pre_valid", m_write_addr_valid, 1'b1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_vec("ar_mw_valid", m_write_addr_valid, 1'b0);
    check_vec("ar_wr_ready", s_write_addr_ready, 1'b0);
    check_vec("ar_mw_addr", m_write_addr, 32'h0);
    check_vec("ar_state", o_dbg_rd_state, 2'd0);
    tick();
    rst_ni = 1'b1;
    m_read_data       = {4{32'hBAD0_0BAD}};
    m_read_data_valid = 1'b1;
    tick();
    m_read_data_valid = 1'b0;
    check_vec("ar_late_valid", s_read_data_valid, 1'b0);
    check_vec("ar_late_data", s_read_data, 128'h0);
    check_vec("ar_count_zero", m_write_addr_valid, 1'b0);
    check_vec("ar_wr_ready_rel", s_write_addr_ready, 1'b1);
    check_vec("ar_rd_ready_rel", s_read_addr_ready, 1'b1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
